// File: rtl/mips_run_monitor_pkg.sv
// Shared definitions for the MIPS run monitor: verdict/state encoding and
// a saturating increment helper used by the event counters.
package mips_run_monitor_pkg;

    localparam int STATUS_W = 3;
    localparam int SAT_W    = 64;

    // Verdict encoding doubles as the FSM state; RUN is the only non-terminal state.
    typedef enum logic [STATUS_W-1:0] {
        ST_RUN     = 3'd0,
        ST_PASS    = 3'd1,
        ST_FAIL    = 3'd2,
        ST_HANG    = 3'd3,
        ST_TIMEOUT = 3'd4,
        ST_BUSERR  = 3'd5
    } state_e;

    // Increment that sticks at max_val; callers zero-extend into SAT_W bits.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                                 input logic [SAT_W-1:0] max_val);
        return (val == max_val) ? val : val + SAT_W'(1);
    endfunction

endpackage

// File: rtl/mips_pc_stall_detect.sv
// Branch-to-self detector: tracks how many consecutive cycles the PC has not
// moved and flags a hang on the HANG_CYCLES-th such cycle.
module mips_pc_stall_detect #(
    parameter int ADDR_W      = 32,
    parameter int HANG_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic [ADDR_W-1:0] inst_adr_i,
    output logic              hang_o
);

    localparam int              CNT_W = $clog2(HANG_CYCLES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(HANG_CYCLES - 1);

    logic [ADDR_W-1:0] prev_pc_q, prev_pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              same_pc;

    assign same_pc = (inst_adr_i == prev_pc_q);
    assign hang_o  = en_i && same_pc && (cnt_q == LAST);

    // Next PC history and stall count; both hold once the run has ended.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
        prev_pc_d = prev_pc_q;
        cnt_d     = cnt_q;
        if (en_i) begin
            prev_pc_d = inst_adr_i;
            if (!same_pc) begin
                cnt_d = '0;
            end else if (cnt_q != LAST) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers; reset compares the first PC against zero.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            prev_pc_q <= '0;
            cnt_q     <= '0;
        end else begin
            prev_pc_q <= prev_pc_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: rtl/mips_run_monitor.sv
// Run-control / verdict block for the single-cycle MIPS benches.
// Watches the instruction and data-memory buses, counts cycles and writes,
// and latches a sticky verdict (PASS/FAIL/HANG/TIMEOUT/BUSERR) until reset.
// Optional feature macro: MIPS_RUN_MONITOR_SIGNATURE_EN (write-stream signature).
module mips_run_monitor
    import mips_run_monitor_pkg::*;
#(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                CNT_W          = 32,
    parameter logic [ADDR_W-1:0] RESULT_ADDR    = ADDR_W'(32'h0000_07FC),
    parameter logic [DATA_W-1:0] PASS_VALUE     = DATA_W'(32'h0000_0001),
    parameter int                HANG_CYCLES    = 16,
    parameter int                TIMEOUT_CYCLES = 3125
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   inst_adr,
    input  logic [ADDR_W-1:0]   data_adr,
    input  logic [DATA_W-1:0]   data_in,
    input  logic                mem_read,
    input  logic                mem_write,
    output logic                done,
    output logic                pass,
    output logic [STATUS_W-1:0] status,
    output logic [CNT_W-1:0]    cycle_cnt,
    output logic [CNT_W-1:0]    write_cnt,
    output logic [DATA_W-1:0]   last_result,
    output logic [DATA_W-1:0]   signature
);

    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0]  write_cnt_q, write_cnt_d;
    logic [DATA_W-1:0] last_result_q, last_result_d;
    logic              run, rd_s, wr_s, mbox_hit, hang;

    // Strobes compared against a known 1 so an unknown strobe never fires an event.
    assign rd_s     = (mem_read === 1'b1);
    assign wr_s     = (mem_write === 1'b1);
    assign run      = (state_q == ST_RUN);
    assign mbox_hit = wr_s && (data_adr == RESULT_ADDR);

    mips_pc_stall_detect #(
        .ADDR_W      (ADDR_W),
        .HANG_CYCLES (HANG_CYCLES)
    ) u_stall (
        .clk        (clk),
        .rst        (rst),
        .en_i       (run),
        .inst_adr_i (inst_adr),
        .hang_o     (hang)
    );

    // Verdict FSM plus counters and mailbox capture; everything freezes outside RUN.
    always_comb begin
        state_d       = state_q;
        cycle_cnt_d   = cycle_cnt_q;
        write_cnt_d   = write_cnt_q;
        last_result_d = last_result_q;
        if (run) begin
            cycle_cnt_d = CNT_W'(sat_inc(SAT_W'(cycle_cnt_q), SAT_W'(CNT_MAX)));
            if (wr_s) begin
                write_cnt_d = CNT_W'(sat_inc(SAT_W'(write_cnt_q), SAT_W'(CNT_MAX)));
            end
            if (mbox_hit) begin
                last_result_d = data_in;
            end
            // Simultaneous events resolve in this order.
            if (rd_s && wr_s) begin
                state_d = ST_BUSERR;
            end else if (mbox_hit) begin
                state_d = (data_in == PASS_VALUE) ? ST_PASS : ST_FAIL;
            end else if (hang) begin
                state_d = ST_HANG;
            end else if (cycle_cnt_q == TIMEOUT_LAST) begin
                state_d = ST_TIMEOUT;
            end
        end
    end

    // Verdict and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            cycle_cnt_q   <= '0;
            write_cnt_q   <= '0;
            last_result_q <= '0;
        end else begin
            state_q       <= state_d;
            cycle_cnt_q   <= cycle_cnt_d;
            write_cnt_q   <= write_cnt_d;
            last_result_q <= last_result_d;
        end
    end

`ifdef MIPS_RUN_MONITOR_SIGNATURE_EN
    logic [DATA_W-1:0] sig_q, sig_d;

    // Rotate-and-xor signature over every write counted during RUN.
    always_comb begin
        sig_d = sig_q;
        if (run && wr_s) begin
            sig_d = {sig_q[DATA_W-2:0], sig_q[DATA_W-1]} ^ data_in ^ DATA_W'(data_adr);
        end
    end

    // Signature register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign signature = sig_q;
`else
    assign signature = '0;
`endif

    assign status      = state_q;
    assign done        = (state_q != ST_RUN);
    assign pass        = (state_q == ST_PASS);
    assign cycle_cnt   = cycle_cnt_q;
    assign write_cnt   = write_cnt_q;
    assign last_result = last_result_q;

endmodule

// File: tb/tb_mips_run_monitor.sv
// Scoreboard bench for mips_run_monitor: each test queues its expected verdict,
// a negedge monitor scores the verdict when done rises.
module tb_mips_run_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] inst_adr = '0, data_adr = '0, data_in = '0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic        done, pass;
    logic [2:0]  status;
    logic [31:0] cycle_cnt, write_cnt, last_result, signature;

    typedef struct {
        string       name;
        logic [2:0]  st;
        logic        ps;
        logic [31:0] cyc;
        logic [31:0] wr;
        logic [31:0] res;
        bit          chk_res;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   seen    = 1'b0;

    always #5 clk = ~clk;

    mips_run_monitor dut (
        .clk         (clk),
        .rst         (rst),
        .inst_adr    (inst_adr),
        .data_adr    (data_adr),
        .data_in     (data_in),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .done        (done),
        .pass        (pass),
        .status      (status),
        .cycle_cnt   (cycle_cnt),
        .write_cnt   (write_cnt),
        .last_result (last_result),
        .signature   (signature)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input string name, input logic [2:0] st, input logic ps,
                            input logic [31:0] cyc, input logic [31:0] wr,
                            input logic [31:0] res, input bit chk_res);
        exp_t e;
        e.name = name; e.st = st; e.ps = ps; e.cyc = cyc;
        e.wr = wr; e.res = res; e.chk_res = chk_res;
        sb.push_back(e);
    endtask

    task automatic score();
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_verdict: status=%0d with no expectation queued", status);
        end else begin
            e = sb.pop_front();
            check({e.name, "_status"}, 32'(status), 32'(e.st));
            check({e.name, "_done"}, 32'(done), 32'd1);
            check({e.name, "_pass"}, 32'(pass), 32'(e.ps));
            check({e.name, "_cycle_cnt"}, cycle_cnt, e.cyc);
            check({e.name, "_write_cnt"}, write_cnt, e.wr);
            if (e.chk_res) check({e.name, "_last_result"}, last_result, e.res);
        end
    endtask

    // Monitor: scores each verdict once, when done is first seen high after reset.
    always @(negedge clk) begin
        if (rst) begin
            seen <= 1'b0;
        end else if (done && !seen) begin
            seen <= 1'b1;
            score();
        end
    end

    task automatic step(input logic [31:0] pc, input logic [31:0] adr, input logic [31:0] din,
                        input logic rd, input logic wr);
        inst_adr = pc; data_adr = adr; data_in = din; mem_read = rd; mem_write = wr;
        @(negedge clk);
    endtask

    task automatic step_pc(input logic [31:0] pc);
        step(pc, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_status"}, 32'(status), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'd0);
        check({tag, "_cycle_cnt"}, cycle_cnt, 32'd0);
        check({tag, "_write_cnt"}, write_cnt, 32'd0);
        check({tag, "_last_result"}, last_result, 32'd0);
        check({tag, "_signature"}, signature, 32'd0);
    endtask

    // Asserts rst between edges, checks the asynchronous clear, releases on a negedge.
    task automatic apply_reset(input string tag);
        #2 rst = 1'b1;
        inst_adr = '0; data_adr = '0; data_in = '0; mem_read = 1'b0; mem_write = 1'b0;
        #1 check_zero(tag);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic expect_scored(input string tag);
        #1 check({tag, "_scored"}, 32'(sb.size()), 32'd0);
    endtask

    // Mailbox PASS at cycle 10 with two ordinary writes before it.
    task automatic run1(input string tag);
        logic [31:0] exp_sig;
`ifdef MIPS_RUN_MONITOR_SIGNATURE_EN
        exp_sig = 32'h0000_0304;
`else
        exp_sig = 32'h0;
`endif
        push_exp(tag, 3'd1, 1'b1, 32'd11, 32'd3, 32'h1, 1'b1);
        for (int i = 0; i <= 10; i++) begin
            if (i == 3)       step(32'(4 * i), 32'h100, 32'h11, 1'b0, 1'b1);
            else if (i == 7)  step(32'(4 * i), 32'h104, 32'h22, 1'b0, 1'b1);
            else if (i == 10) step(32'(4 * i), 32'h7FC, 32'h1, 1'b0, 1'b1);
            else              step_pc(32'(4 * i));
            if (i == 7) begin
                check({tag, "_signature"}, signature, exp_sig);
                check({tag, "_running"}, 32'(done), 32'd0);
            end
        end
        expect_scored(tag);
    endtask

    initial begin
        logic [31:0] exp_sig;

        // Power-on reset, about 20 ns.
        #1 rst = 1'b1;
        #2 check_zero("por");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1: mailbox pass.
        run1("pass");

        // 2: mailbox fail; later writes are ignored.
        apply_reset("rst_after_pass");
        push_exp("fail", 3'd2, 1'b0, 32'd6, 32'd1, 32'hDEAD_BEEF, 1'b1);
        for (int i = 0; i <= 5; i++) begin
            if (i == 5) step(32'(4 * i), 32'h7FC, 32'hDEAD_BEEF, 1'b0, 1'b1);
            else        step_pc(32'(4 * i));
        end
        expect_scored("fail");
        step(32'd24, 32'h7FC, 32'h1, 1'b0, 1'b1);
        step(32'd28, 32'h100, 32'h55, 1'b0, 1'b1);
        step(32'd32, 32'h7FC, 32'h1, 1'b0, 1'b1);
        check("fail_frozen_result", last_result, 32'hDEAD_BEEF);
        check("fail_frozen_wcnt", write_cnt, 32'd1);
        check("fail_frozen_ccnt", cycle_cnt, 32'd6);
        check("fail_frozen_status", 32'(status), 32'd2);
`ifdef MIPS_RUN_MONITOR_SIGNATURE_EN
        exp_sig = 32'hDEAD_B913;
`else
        exp_sig = 32'h0;
`endif
        check("fail_frozen_sig", signature, exp_sig);

        // 3: PC stuck at 0x40 from cycle 5; hang on the 16th equal cycle (cycle 21).
        apply_reset("rst_after_fail");
        push_exp("hang", 3'd3, 1'b0, 32'd22, 32'd0, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) step_pc(32'(4 * i));
        for (int k = 0; k < 40 && !done; k++) step_pc(32'h40);
        check("hang_reached", 32'(done), 32'd1);
        expect_scored("hang");
        for (int k = 0; k < 3; k++) step_pc(32'h40);
        check("hang_frozen_ccnt", cycle_cnt, 32'd22);
        check("hang_frozen_status", 32'(status), 32'd3);

        // 3b: PC held at 0 from reset; first compare is against 0, hang at cycle 15.
        apply_reset("rst_after_hang");
        push_exp("hang0", 3'd3, 1'b0, 32'd16, 32'd0, 32'h0, 1'b1);
        for (int k = 0; k < 30 && !done; k++) step_pc(32'h0);
        check("hang0_reached", 32'(done), 32'd1);
        expect_scored("hang0");

        // 3c: mailbox write in the cycle the hang would fire; the result wins.
        apply_reset("rst_after_hang0");
        push_exp("res_over_hang", 3'd1, 1'b1, 32'd16, 32'd1, 32'h1, 1'b1);
        for (int k = 0; k < 15; k++) step_pc(32'h0);
        step(32'h0, 32'h7FC, 32'h1, 1'b0, 1'b1);
        expect_scored("res_over_hang");

        // 4: timeout with an incrementing PC.
        apply_reset("rst_before_timeout");
        push_exp("timeout", 3'd4, 1'b0, 32'd3125, 32'd0, 32'h0, 1'b1);
        for (int i = 0; i < 3200 && !done; i++) step_pc(32'(4 * i));
        check("timeout_reached", 32'(done), 32'd1);
        expect_scored("timeout");

        // 5: read and write together on the mailbox -> BUSERR, write counted.
        apply_reset("rst_after_timeout");
        push_exp("buserr", 3'd5, 1'b0, 32'd4, 32'd1, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) step_pc(32'(4 * i));
        step(32'd12, 32'h7FC, 32'h1, 1'b1, 1'b1);
        expect_scored("buserr");

        // 6: reset mid-run, rerun of test 1, then reset after the verdict.
        apply_reset("rst_after_buserr");
        step_pc(32'd0);
        step(32'd4, 32'h100, 32'h11, 1'b0, 1'b1);
        step_pc(32'd8);
        step_pc(32'd12);
        check("midrun_ccnt", cycle_cnt, 32'd4);
        apply_reset("rst_midrun");
        run1("rerun");
        apply_reset("rst_post_verdict");

        check("sb_empty_at_end", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
